// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit.
// Radix-2 shift-add multiplier and restoring divider, one bit per cycle,
// sharing a single 2*XLEN accumulator. Divide-by-zero and signed overflow
// bypass the iteration and complete one cycle after the start edge.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc_q, acc_d;     // mul: {hi, lo/multiplier}; div: {remainder, quotient}
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand decode at the request: signedness, magnitudes, fast-path detection.
  logic            a_signed, b_signed, sa, sb, neg_in;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;
  logic            div_zero, div_ovf;

  always_comb begin
    a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
               (op_i == OP_DIV)  || (op_i == OP_REM);
    b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    sa       = a_signed & rs1_i[XLEN-1];
    sb       = b_signed & rs2_i[XLEN-1];
    a_mag    = sa ? -rs1_i : rs1_i;
    b_mag    = sb ? -rs2_i : rs2_i;
    // Remainder takes the dividend's sign; product/quotient the XOR.
    neg_in   = (op_i[2] && op_i[1]) ? sa : (sa ^ sb);
    div_zero = op_i[2] && (rs2_i == '0);
    div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
               (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
    if (div_zero) fast_res = op_i[1] ? rs1_i : '1;
    else          fast_res = op_i[1] ? '0    : rs1_i;
  end

  // One iteration step of each algorithm, from the current accumulator.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic              div_borrow;

  always_comb begin
    mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next   = {mul_sum, acc_q[XLEN-1:1]};
    div_shift  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff   = {1'b0, div_shift} - {2'b00, opnd_q};
    div_borrow = div_diff[XLEN+1];
    div_next   = {(div_borrow ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
                  acc_q[XLEN-2:0], ~div_borrow};
  end

  // Sign fix-up and result selection at the end of the iteration.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                  fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU,
      OP_MULHU:                fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:         fix_res = quo_fix;
      default:                 fix_res = rem_fix;
    endcase
  end

  // Next-state logic for the control FSM and datapath registers.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a variable unassigned, which would infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (start_i) begin
            op_d   = op_i;
            neg_d  = neg_in;
            cnt_d  = '0;
            opnd_d = op_i[2] ? b_mag : a_mag;
            acc_d  = {{XLEN{1'b0}}, (op_i[2] ? a_mag : b_mag)};
            if (div_zero || div_ovf) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              result_d = fast_res;
            end else begin
              state_d = S_CALC;
              busy_d  = 1'b1;
            end
          end
        end
        S_CALC: begin
          acc_d  = op_q[2] ? div_next : mul_next;
          cnt_d  = cnt_q + CW'(1);
          busy_d = 1'b1;
          if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
        end
        S_FIX: begin
          result_d = fix_res;
          state_d  = S_DONE;
          done_d   = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (!rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed vector table, multi-cycle
// corner sequences (flush, ignored start, mid-op reset) and random ops
// against an arithmetic reference model; plus a 64-bit instance.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result;

  logic        start64, flush64;
  logic [2:0]  op64;
  logic [63:0] rs1_64, rs2_64;
  logic        busy64, done64;
  logic [63:0] result64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.XLEN(32)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .flush_i(flush),
    .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .busy_o(busy), .done_o(done), .result_o(result)
  );

  muldiv_iter #(.XLEN(64)) u_dut64 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start64), .flush_i(flush64),
    .op_i(op64), .rs1_i(rs1_64), .rs2_i(rs2_64),
    .busy_o(busy64), .done_o(done64), .result_o(result64)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic following the RISC-V M rules.
  function automatic logic [31:0] ref32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    sp = '0;
    up = '0;
    case (f)
      3'd0: begin up = ua * ub;           return up[31:0];  end
      3'd1: begin sp = sa * sb;           return sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub);  return sp[63:32]; end
      3'd3: begin up = ua * ub;           return up[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; sp = sa / sb; return sp[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; up = ua / ub; return up[31:0]; end
      3'd6: begin if (b == 0) return a; sp = sa % sb; return sp[31:0]; end
      default: begin if (b == 0) return a; up = ua % ub; return up[31:0]; end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one request and wait (bounded) for done; leaves the bench in the DONE cycle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int bcnt);
    op = f; rs1 = a; rs2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    res = result;
  endtask

  task automatic run64(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output int lat);
    op64 = f; rs1_64 = a; rs2_64 = b; start64 = 1'b1;
    tick();
    start64 = 1'b0;
    lat = 1;
    while (!done64 && lat < 200) begin
      tick();
      lat++;
    end
    res = result64;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t        vecs [12];
    logic [31:0] res, a, b;
    logic [63:0] res64;
    logic [2:0]  f;
    int          lat, bcnt, dcnt;

    vecs = '{
      '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
      '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000},
      '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
      '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
      '{3'd5, 32'd100,        32'd7,         32'd14},
      '{3'd7, 32'd100,        32'd7,         32'd2},
      '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF},
      '{3'd7, 32'd5,          32'd0,         32'd5},
      '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
      '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0}
    };

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    start64 = 1'b0; flush64 = 1'b0; op64 = '0; rs1_64 = '0; rs2_64 = '0;
    repeat (3) tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    rst_n = 1'b1;
    tick();

    // Directed table; consecutive entries start in the DONE cycle (back-to-back).
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bcnt);
      check($sformatf("vec%0d result", i), res, vecs[i].exp);
      check($sformatf("vec%0d latency", i), lat, exp_lat(vecs[i].op, vecs[i].a, vecs[i].b));
      check($sformatf("vec%0d busy cycles", i), bcnt, (exp_lat(vecs[i].op, vecs[i].a, vecs[i].b) == 1) ? 0 : 33);
    end
    tick();
    check("done single pulse", done, 0);
    check("idle busy", busy, 0);

    // start_i during CALC is ignored.
    op = 3'd0; rs1 = 32'd6; rs2 = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    repeat (2) begin tick(); lat++; end
    op = 3'd5; rs1 = 32'd9; rs2 = 32'd3; start = 1'b1;
    tick(); lat++;
    start = 1'b0;
    while (!done && lat < 100) begin tick(); lat++; end
    check("ignored start result", result, 42);
    check("ignored start latency", lat, 34);

    // Flush at CALC cycle 10: no done, result kept.
    run_op(3'd5, 32'd100, 32'd7, res, lat, bcnt);
    check("pre-flush result", res, 14);
    tick();
    op = 3'd0; rs1 = 32'd3; rs2 = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("busy before flush", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", busy, 0);
    check("flush done", done, 0);
    check("flush result kept", result, 14);
    dcnt = 0;
    repeat (40) begin tick(); if (done || busy) dcnt++; end
    check("no activity after flush", dcnt, 0);

    // flush together with start: request dropped.
    op = 3'd0; rs1 = 32'd2; rs2 = 32'd2; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    dcnt = 0;
    repeat (40) begin if (done || busy) dcnt++; tick(); end
    check("flush beats start", dcnt, 0);
    run_op(3'd0, 32'd3, 32'd5, res, lat, bcnt);
    check("post-flush result", res, 15);
    check("post-flush latency", lat, 34);

    // Reset at CALC cycle 5 discards the operation.
    tick();
    op = 3'd3; rs1 = 32'hFFFF; rs2 = 32'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check("midop reset busy", busy, 0);
    check("midop reset done", done, 0);
    check("midop reset result", result, 0);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (40) begin tick(); if (done || busy) dcnt++; end
    check("idle after reset", dcnt, 0);

    // Random operations against the reference model.
    for (int n = 0; n < 60; n++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op(f, a, b, res, lat, bcnt);
      check($sformatf("rand%0d op%0d %h,%h", n, f, a, b), res, ref32(f, a, b));
      check($sformatf("rand%0d latency", n), lat, exp_lat(f, a, b));
    end
    tick();

    // 64-bit configuration.
    run64(3'd0, 64'd3, 64'd5, res64, lat);
    check("x64 mul result", res64, 64'd15);
    check("x64 mul latency", lat, 66);
    run64(3'd3, '1, '1, res64, lat);
    check("x64 mulhu result", res64, 64'hFFFF_FFFF_FFFF_FFFE);
    run64(3'd4, 64'h8000_0000_0000_0000, '1, res64, lat);
    check("x64 div ovf result", res64, 64'h8000_0000_0000_0000);
    check("x64 div ovf latency", lat, 1);
    run64(3'd6, -64'sd7, 64'd2, res64, lat);
    check("x64 rem result", res64, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Iterative RV32M/RV64M multiply–divide unit for the EX stage of the pipelined core. Executes all eight M-extension operations on latched operands using a radix-2 shift-add multiplier and a restoring divider, one bit per cycle. Exposes a start/busy/done handshake so the hazard logic can stall IF/ID/EX while an operation runs. Divide-by-zero and signed overflow follow the RISC-V specification and complete on a short fast path.

## Interface
- XLEN, 32, operand/result width (32 or 64)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-low
- start_i  in  1  request; accepted only in IDLE or DONE
- flush_i  in  1  abort current operation (branch/flush from pipeline)
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_i  in  XLEN  operand A / dividend
- rs2_i  in  XLEN  operand B / divisor
- busy_o  out  1  high in CALC and FIX
- done_o  out  1  one-cycle pulse, result_o valid
- result_o  out  XLEN  result, held until next done_o

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start_i at edge: latch op, operands, sign flags. If op is DIV/REM class and rs2=0, or signed DIV/REM with rs1=most-negative and rs2=all-ones, go DONE directly with special result; otherwise go CALC, counter=0.
- Signed operands (MUL* per op: MULH both signed, MULHSU rs1 signed/rs2 unsigned, MULHU/MUL treated unsigned on magnitudes with sign fix; DIV/REM signed, DIVU/REMU unsigned) converted to magnitudes at latch; negate flag = sign(A) XOR sign(B) for product/quotient, sign(A) for remainder.
- CALC: one iteration per edge, counter increments; after XLEN iterations go FIX. Multiply: 2·XLEN-bit accumulator, shift-add. Divide: XLEN-bit remainder, XLEN-bit quotient, restoring subtract of XLEN+1 bits.
- FIX: apply two's-complement negation if negate flag set; select low half (MUL), high half (MULH*), quotient or remainder; write result_o; go DONE.
- DONE: done_o=1 for exactly this cycle; without start_i go IDLE.
- Special results: x/0 → quotient all-ones, remainder = rs1; overflow → quotient = rs1 (most-negative), remainder = 0.
- start_i in CALC/FIX ignored (no queueing).
- flush_i: highest priority after reset; from any state go IDLE next edge, no done_o, result_o unchanged. flush_i with start_i in same cycle: flush wins, request dropped.
- All arithmetic modulo 2^XLEN for results; no exceptions raised.

## Timing
- Reset (rst_i low at edge): state IDLE, busy_o=0, done_o=0, result_o=0, counter=0, internal registers 0. Reset mid-operation discards it.
- Normal op: start edge k → busy_o high from k+1 through k+XLEN+1 (XLEN CALC cycles + 1 FIX) → done_o high cycle k+XLEN+2. Latency XLEN+2 (34 for XLEN=32).
- Fast path: done_o high at cycle k+1, busy_o never asserts.
- Back-to-back: start_i during DONE accepted; done_o of second op follows the same latency from that edge; no idle gap required.
- Outputs all registered; no combinational path from inputs to outputs.

## Test plan
- Reset then MUL rs1=7, rs2=0xFFFFFFFD → result 0xFFFFFFEB, done_o exactly 34 cycles after start edge, busy_o high 33 cycles.
- MULHU/MULH/MULHSU with rs1=rs2=0xFFFFFFFF → 0xFFFFFFFE / 0x00000000 / 0xFFFFFFFF respectively.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; back-to-back starts in DONE cycle, each done_o one pulse.
- DIV 5/0 → 0xFFFFFFFF, REMU 5/0 → 5, DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM same → 0; each done_o one cycle after start, busy_o stays 0.
- Start MUL, assert flush_i at CALC cycle 10 → busy_o low next cycle, no done_o, result_o unchanged; start_i pulses during CALC ignored; subsequent op completes correctly.
- rst_i low at CALC cycle 5 → next edge all outputs 0, state IDLE; rerun with XLEN=64: MUL 3×5 → 15, done_o 66 cycles after start.
